// File: rtl/fpu_misc_pipe_if.sv
// Handshake/data bundle for the FP misc pipeline (sign-inject, min/max, compare, classify).
interface fpu_misc_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         ivalid;
  logic         oready;
  logic [3:0]   iop;
  logic [W-1:0] idataa;
  logic [W-1:0] idatab;
  logic         ovalid;
  logic         iready;
  logic [W-1:0] oresult;
  logic [4:0]   oflags;
  logic [4:0]   osticky;
  logic         iflags_clr;
  logic         obusy;

  modport master (
    output ivalid, iop, idataa, idatab, iready, iflags_clr,
    input  oready, ovalid, oresult, oflags, osticky, obusy
  );

  modport slave (
    input  ivalid, iop, idataa, idatab, iready, iflags_clr,
    output oready, ovalid, oresult, oflags, osticky, obusy
  );
endinterface

// File: rtl/fpu_misc_pipe.sv
// Pipelined non-arithmetic FP unit: SGNJ/SGNJN/SGNJX, MIN/MAX, FEQ/FLT/FLE, FCLASS.
// Result is computed combinationally at the input and carried through LATENCY
// stages under a single global advance; sticky flags accumulate on output handshakes.
module fpu_misc_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input  logic          iclock,
  input  logic          ireset,
  fpu_misc_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_SGNJ   = 4'd0,
    OP_SGNJN  = 4'd1,
    OP_SGNJX  = 4'd2,
    OP_MIN    = 4'd3,
    OP_MAX    = 4'd4,
    OP_FEQ    = 4'd5,
    OP_FLT    = 4'd6,
    OP_FLE    = 4'd7,
    OP_FCLASS = 4'd8
  } op_e;

  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic [W-2:0]       mag_a, mag_b;
  logic               a_nan, b_nan, a_snan, b_snan, a_qnan;
  logic               a_inf, a_zero, b_zero, a_sub, a_norm;
  logic               any_nan, any_snan, both_zero, lt_s, eq_v;
  logic [9:0]         cls;
  logic [W-1:0]       comp_res;
  logic [4:0]         comp_flg;

  logic               advance, accept, hs;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [W-1:0]       res_q [LATENCY];
  logic [W-1:0]       res_d [LATENCY];
  logic [4:0]         flg_q [LATENCY];
  logic [4:0]         flg_d [LATENCY];
  logic [4:0]         sticky_q, sticky_d;

  // Operand decode, classification and signed ordering
  always_comb begin
    {sa, ea, ma} = bus.idataa;
    {sb, eb, mb} = bus.idatab;
    mag_a     = bus.idataa[W-2:0];
    mag_b     = bus.idatab[W-2:0];
    a_nan     = (&ea) & (|ma);
    b_nan     = (&eb) & (|mb);
    a_snan    = a_nan & ~ma[MAN_W-1];
    b_snan    = b_nan & ~mb[MAN_W-1];
    a_qnan    = a_nan & ma[MAN_W-1];
    a_inf     = (&ea) & ~(|ma);
    a_zero    = (mag_a == '0);
    b_zero    = (mag_b == '0);
    a_sub     = ~(|ea) & (|ma);
    a_norm    = (|ea) & ~(&ea);
    any_nan   = a_nan | b_nan;
    any_snan  = a_snan | b_snan;
    both_zero = a_zero & b_zero;
    // Orders -0 below +0; FLT/FLE mask that case with both_zero.
    lt_s      = (sa != sb) ? sa : (sa ? (mag_a > mag_b) : (mag_a < mag_b));
    eq_v      = (bus.idataa == bus.idatab) | both_zero;
    cls = {a_qnan, a_snan,
           ~sa & a_inf, ~sa & a_norm, ~sa & a_sub, ~sa & a_zero,
           sa & a_zero, sa & a_sub, sa & a_norm, sa & a_inf};
  end

  // Per-op result and NV flag
  always_comb begin
    comp_res = '0;
    comp_flg = '0;
    case (bus.iop)
      OP_SGNJ:  comp_res = {sb, mag_a};
      OP_SGNJN: comp_res = {~sb, mag_a};
      OP_SGNJX: comp_res = {sa ^ sb, mag_a};
      OP_MIN, OP_MAX: begin
        comp_flg[4] = any_snan;
        if (a_nan && b_nan)  comp_res = CANON_NAN;
        else if (a_nan)      comp_res = bus.idatab;
        else if (b_nan)      comp_res = bus.idataa;
        else if (bus.iop == OP_MIN) comp_res = lt_s ? bus.idataa : bus.idatab;
        else                 comp_res = lt_s ? bus.idatab : bus.idataa;
      end
      OP_FEQ: begin
        comp_res[0] = ~any_nan & eq_v;
        comp_flg[4] = any_snan;
      end
      OP_FLT: begin
        comp_res[0] = ~any_nan & lt_s & ~both_zero;
        comp_flg[4] = any_nan;
      end
      OP_FLE: begin
        comp_res[0] = ~any_nan & (lt_s | eq_v);
        comp_flg[4] = any_nan;
      end
      OP_FCLASS: comp_res[9:0] = cls;
      default: ;
    endcase
  end

  // Global pipeline advance and stage shifting
  always_comb begin
    advance = ~vld_q[LATENCY-1] | bus.iready;
    accept  = bus.ivalid & advance;
    vld_d   = vld_q;
    res_d   = res_q;
    flg_d   = flg_q;
    if (advance) begin
      vld_d[0] = accept;
      res_d[0] = accept ? comp_res : '0;
      flg_d[0] = accept ? comp_flg : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        flg_d[i] = flg_q[i-1];
      end
    end
  end

  // Sticky flags: a clear coinciding with a handshake keeps that handshake's flags
  always_comb begin
    hs       = vld_q[LATENCY-1] & bus.iready;
    sticky_d = sticky_q;
    if (hs)             sticky_d = sticky_q | flg_q[LATENCY-1];
    if (bus.iflags_clr) sticky_d = hs ? flg_q[LATENCY-1] : '0;
  end

  // State registers
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      vld_q    <= '0;
      res_q    <= '{default: '0};
      flg_q    <= '{default: '0};
      sticky_q <= '0;
    end else begin
      vld_q    <= vld_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.oready  = advance;
  assign bus.ovalid  = vld_q[LATENCY-1];
  assign bus.oresult = res_q[LATENCY-1];
  assign bus.oflags  = flg_q[LATENCY-1];
  assign bus.osticky = sticky_q;
  assign bus.obusy   = |vld_q;
endmodule

// File: tb/tb_fpu_misc_pipe.sv
// Directed scoreboard bench for fpu_misc_pipe: a LATENCY=2 and a LATENCY=3 instance
// share one clock/reset; expected results are queued at input acceptance.
module tb_fpu_misc_pipe;
  localparam logic [3:0] SGNJ = 4'd0, SGNJN = 4'd1, SGNJX = 4'd2, MIN = 4'd3, MAX = 4'd4;
  localparam logic [3:0] FEQ = 4'd5, FLT = 4'd6, FLE = 4'd7, FCLASS = 4'd8, ILL = 4'd12;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;
  int   n_out3 = 0;
  bit   chk_lat = 1'b0;
  bit   acc2, acc3;
  logic [31:0] exp2_res, exp3_res;
  logic [4:0]  exp2_flg, exp3_flg;
  exp_t q2[$];
  exp_t q3[$];

  fpu_misc_pipe_if #(.EXP_W(8), .MAN_W(23)) bus2 ();
  fpu_misc_pipe_if #(.EXP_W(8), .MAN_W(23)) bus3 ();

  fpu_misc_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(2)) u_dut2 (
    .iclock(clk), .ireset(rst), .bus(bus2.slave));
  fpu_misc_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(3)) u_dut3 (
    .iclock(clk), .ireset(rst), .bus(bus3.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: score outputs and acceptances before the edge, then advance.
  task automatic step();
    exp_t e;
    #1;
    if (bus2.ovalid && bus2.iready) begin
      if (q2.size() == 0) check("L2 spurious output", 32'(bus2.ovalid), 32'd0);
      else begin
        e = q2.pop_front();
        check("L2 result", bus2.oresult, e.res);
        check("L2 flags", 32'(bus2.oflags), 32'(e.flg));
        if (chk_lat) check("L2 latency", 32'(cyc_n - e.cyc), 32'd2);
      end
    end
    if (bus3.ovalid && bus3.iready) begin
      if (q3.size() == 0) check("L3 spurious output", 32'(bus3.ovalid), 32'd0);
      else begin
        e = q3.pop_front();
        n_out3++;
        check("L3 result", bus3.oresult, e.res);
        check("L3 flags", 32'(bus3.oflags), 32'(e.flg));
      end
    end
    acc2 = bus2.ivalid && bus2.oready;
    acc3 = bus3.ivalid && bus3.oready;
    if (acc2) q2.push_back('{exp2_res, exp2_flg, cyc_n});
    if (acc3) q3.push_back('{exp3_res, exp3_flg, cyc_n});
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic issue2(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [4:0] f);
    int tries = 0;
    bus2.iop = op; bus2.idataa = a; bus2.idatab = b; bus2.ivalid = 1'b1;
    exp2_res = r; exp2_flg = f;
    do begin step(); tries++; end while (!acc2 && tries < 20);
    if (!acc2) check("L2 accept timeout", 32'(bus2.oready), 32'd1);
  endtask

  task automatic issue3(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [4:0] f);
    int tries = 0;
    bus3.iop = op; bus3.idataa = a; bus3.idatab = b; bus3.ivalid = 1'b1;
    exp3_res = r; exp3_flg = f;
    do begin step(); tries++; end while (!acc3 && tries < 20);
    if (!acc3) check("L3 accept timeout", 32'(bus3.oready), 32'd1);
  endtask

  task automatic idle_in();
    bus2.ivalid = 1'b0;
    bus3.ivalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle_in();
    while ((q2.size() != 0 || q3.size() != 0 || bus2.obusy || bus3.obusy) && n < 40) begin
      step();
      n++;
    end
    check("drain L2 obusy", 32'(bus2.obusy), 32'd0);
    check("drain L3 obusy", 32'(bus3.obusy), 32'd0);
    check("drain L2 pending", 32'(q2.size()), 32'd0);
    check("drain L3 pending", 32'(q3.size()), 32'd0);
  endtask

  task automatic wait_ovalid2();
    int n = 0;
    while (!bus2.ovalid && n < 10) begin step(); n++; end
    if (!bus2.ovalid) check("L2 ovalid timeout", 32'(bus2.ovalid), 32'd1);
  endtask

  task automatic clr_step();
    bus2.iflags_clr = 1'b1;
    step();
    bus2.iflags_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus2.ivalid = 1'b0; bus2.iop = '0; bus2.idataa = '0; bus2.idatab = '0;
    bus2.iready = 1'b1; bus2.iflags_clr = 1'b0;
    bus3.ivalid = 1'b0; bus3.iop = '0; bus3.idataa = '0; bus3.idatab = '0;
    bus3.iready = 1'b1; bus3.iflags_clr = 1'b0;
    exp2_res = '0; exp2_flg = '0; exp3_res = '0; exp3_flg = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset L2 ovalid", 32'(bus2.ovalid), 32'd0);
    check("reset L2 oresult", bus2.oresult, 32'd0);
    check("reset L2 oflags", 32'(bus2.oflags), 32'd0);
    check("reset L2 osticky", 32'(bus2.osticky), 32'd0);
    check("reset L2 obusy", 32'(bus2.obusy), 32'd0);
    check("reset L3 ovalid", 32'(bus3.ovalid), 32'd0);
    check("reset L3 obusy", 32'(bus3.obusy), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("idle L2 oready", 32'(bus2.oready), 32'd1);

    // Back-to-back stream on the LATENCY=2 unit with exact latency tracking
    chk_lat = 1'b1;
    issue2(FCLASS, 32'hFF800000, '0, 32'h001, 5'h00);
    issue2(FCLASS, 32'h80000000, '0, 32'h008, 5'h00);
    issue2(FCLASS, 32'h00000000, '0, 32'h010, 5'h00);
    issue2(FCLASS, 32'h7F800001, '0, 32'h100, 5'h00);
    issue2(FCLASS, 32'h7FC00000, '0, 32'h200, 5'h00);
    issue2(FCLASS, 32'h00000001, '0, 32'h020, 5'h00);
    issue2(FCLASS, 32'h3F800000, '0, 32'h040, 5'h00);
    issue2(FCLASS, 32'h7F800000, '0, 32'h080, 5'h00);
    issue2(FCLASS, 32'h807FFFFF, '0, 32'h004, 5'h00);
    issue2(FCLASS, 32'hBF800000, '0, 32'h002, 5'h00);
    issue2(MIN, 32'h7F800001, 32'h3F800000, 32'h3F800000, 5'h10);
    issue2(MAX, 32'h7FC00000, 32'h7FC00001, 32'h7FC00000, 5'h00);
    issue2(MIN, 32'h80000000, 32'h00000000, 32'h80000000, 5'h00);
    issue2(MAX, 32'h80000000, 32'h00000000, 32'h00000000, 5'h00);
    issue2(MAX, 32'hC0000000, 32'hBF800000, 32'hBF800000, 5'h00);
    issue2(MIN, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 5'h00);
    issue2(FEQ, 32'h7FC00000, 32'h3F800000, 32'h0, 5'h00);
    issue2(FLT, 32'h7FC00000, 32'h3F800000, 32'h0, 5'h10);
    issue2(FLE, 32'h80000000, 32'h00000000, 32'h1, 5'h00);
    issue2(FEQ, 32'hBF800000, 32'hBF800000, 32'h1, 5'h00);
    issue2(FEQ, 32'h7F800001, 32'h00000000, 32'h0, 5'h10);
    issue2(FLT, 32'h80000000, 32'h00000000, 32'h0, 5'h00);
    issue2(FLT, 32'h3F800000, 32'h40000000, 32'h1, 5'h00);
    issue2(FLT, 32'hC0000000, 32'hBF800000, 32'h1, 5'h00);
    issue2(FLE, 32'h40000000, 32'h3F800000, 32'h0, 5'h00);
    issue2(SGNJ, 32'h3F800000, 32'h80000000, 32'hBF800000, 5'h00);
    issue2(SGNJN, 32'hBF800000, 32'h80000000, 32'h3F800000, 5'h00);
    issue2(SGNJX, 32'hFF800001, 32'h80000000, 32'h7F800001, 5'h00);
    issue2(ILL, 32'h3F800000, 32'h3F800000, 32'h0, 5'h00);
    drain();
    chk_lat = 1'b0;

    // Backpressure on the LATENCY=3 unit
    issue3(SGNJX, 32'h3F800000, 32'h00000000, 32'h3F800000, 5'h00);
    issue3(SGNJX, 32'h3F800000, 32'h80000000, 32'hBF800000, 5'h00);
    issue3(SGNJX, 32'h3F800000, 32'h00000000, 32'h3F800000, 5'h00);
    check("L3 ovalid before stall", 32'(bus3.ovalid), 32'd1);
    bus3.iop = SGNJX; bus3.idataa = 32'h3F800000; bus3.idatab = 32'h80000000;
    exp3_res = 32'hBF800000; exp3_flg = 5'h00;
    bus3.iready = 1'b0;
    repeat (4) begin
      #1;
      check("L3 oready in stall", 32'(bus3.oready), 32'd0);
      check("L3 ovalid in stall", 32'(bus3.ovalid), 32'd1);
      check("L3 result held", bus3.oresult, 32'h3F800000);
      step();
    end
    bus3.iready = 1'b1;
    issue3(SGNJX, 32'h3F800000, 32'h80000000, 32'hBF800000, 5'h00);
    issue3(SGNJX, 32'h3F800000, 32'h00000000, 32'h3F800000, 5'h00);
    issue3(SGNJX, 32'h3F800000, 32'h80000000, 32'hBF800000, 5'h00);
    drain();
    check("L3 delivered count", 32'(n_out3), 32'd6);

    // Sticky flags
    clr_step();
    check("sticky after clear", 32'(bus2.osticky), 32'h00);
    issue2(FLT, 32'h7FC00000, 32'h3F800000, 32'h0, 5'h10);
    drain();
    check("sticky NV handshake", 32'(bus2.osticky), 32'h10);
    clr_step();
    check("sticky clr alone", 32'(bus2.osticky), 32'h00);
    issue2(FLT, 32'h7FC00000, 32'h3F800000, 32'h0, 5'h10);
    drain();
    check("sticky NV again", 32'(bus2.osticky), 32'h10);
    issue2(FEQ, 32'h3F800000, 32'h3F800000, 32'h1, 5'h00);
    idle_in();
    wait_ovalid2();
    clr_step();
    check("sticky clr+clean hs", 32'(bus2.osticky), 32'h00);
    issue2(FLT, 32'h7FC00000, 32'h3F800000, 32'h0, 5'h10);
    idle_in();
    wait_ovalid2();
    clr_step();
    check("sticky clr+NV hs", 32'(bus2.osticky), 32'h10);
    drain();

    // Asynchronous reset with two entries in flight
    issue2(FCLASS, 32'h00000000, '0, 32'h010, 5'h00);
    issue2(FCLASS, 32'h80000000, '0, 32'h008, 5'h00);
    idle_in();
    check("pre-reset L2 obusy", 32'(bus2.obusy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midreset L2 ovalid", 32'(bus2.ovalid), 32'd0);
    check("midreset L2 obusy", 32'(bus2.obusy), 32'd0);
    check("midreset L2 osticky", 32'(bus2.osticky), 32'd0);
    q2.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    repeat (5) begin
      check("post-reset L2 ovalid", 32'(bus2.ovalid), 32'd0);
      step();
    end
    check("post-reset L2 obusy", 32'(bus2.obusy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
